alarm_controller: RTL and testbench

- Downstream consumer of the seconds/minutes/hours counter values; implements a single daily alarm for the 24-hour clock.
- Holds a user-set alarm time, compares it against the running time and drives a ringing flag and a 1 Hz buzzer pattern.
- Supports stop, snooze and automatic ring timeout.
- Output feeds LEDR/buzzer logic; alarm time feeds the HEX mux in set mode.

---
 rtl/alarm_controller.sv | 173 +++++++++++++++++
 tb/tb_alarm_controller.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// Single daily alarm for the 24-hour clock: stores the alarm time, detects the
// match against the running counters and sequences ringing, snooze and timeout.
module alarm_controller #(
    parameter int unsigned RING_SECONDS   = 60,
    parameter int unsigned SNOOZE_SECONDS = 300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic [5:0] count_sec,
    input  logic [5:0] count_min,
    input  logic [4:0] count_hour,
    input  logic       arm,
    input  logic       set_mode,
    input  logic       btn_hour,
    input  logic       btn_min,
    input  logic       btn_stop,
    input  logic       btn_snooze,
    output logic [4:0] alarm_hour,
    output logic [5:0] alarm_min,
    output logic       ringing,
    output logic       buzz,
    output logic       armed
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } state_e;

    localparam logic [7:0]  RING_LIM   = 8'(RING_SECONDS);
    localparam logic [15:0] SNOOZE_LIM = 16'(SNOOZE_SECONDS);

    state_e      state_q, state_d;
    logic [7:0]  ring_cnt_q, ring_cnt_d;
    logic [15:0] snooze_cnt_q, snooze_cnt_d;
    logic        buzz_q, buzz_d;
    logic        ringing_q, ringing_d;
    logic        armed_q, armed_d;
    logic [4:0]  alarm_hour_q, alarm_hour_d;
    logic [5:0]  alarm_min_q, alarm_min_d;
    logic        match_q;

    logic        match_now;
    logic        trigger;
    logic [7:0]  ring_cnt_inc;
    logic [15:0] snooze_cnt_inc;

    assign match_now = (count_hour == alarm_hour_q) && (count_min == alarm_min_q)
                       && (count_sec == 6'd0);
    // Edge-detect so a match held over many cycles (or re-entered after set mode) fires once.
    assign trigger        = match_now & ~match_q;
    assign ring_cnt_inc   = ring_cnt_q + 8'd1;
    assign snooze_cnt_inc = snooze_cnt_q + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ring_cnt_q   <= '0;
            snooze_cnt_q <= '0;
            buzz_q       <= 1'b0;
            ringing_q    <= 1'b0;
            armed_q      <= 1'b0;
            alarm_hour_q <= '0;
            alarm_min_q  <= '0;
            match_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ring_cnt_q   <= ring_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
            buzz_q       <= buzz_d;
            ringing_q    <= ringing_d;
            armed_q      <= armed_d;
            alarm_hour_q <= alarm_hour_d;
            alarm_min_q  <= alarm_min_d;
            match_q      <= match_now;
        end
    end

    always_comb begin
        alarm_hour_d = alarm_hour_q;
        alarm_min_d  = alarm_min_q;
        if (set_mode) begin
            if (btn_hour) begin
                alarm_hour_d = (alarm_hour_q == 5'd23) ? 5'd0 : alarm_hour_q + 5'd1;
            end
            if (btn_min) begin
                alarm_min_d = (alarm_min_q == 6'd59) ? 6'd0 : alarm_min_q + 6'd1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ring_cnt_d   = ring_cnt_q;
        snooze_cnt_d = snooze_cnt_q;
        buzz_d       = buzz_q;
        if (!arm) begin
            state_d      = IDLE;
            ring_cnt_d   = '0;
            snooze_cnt_d = '0;
            buzz_d       = 1'b0;
        end else if (set_mode) begin
            state_d = ARMED;
            buzz_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = ARMED;
                end
                ARMED: begin
                    if (trigger) begin
                        state_d    = RINGING;
                        ring_cnt_d = '0;
                        buzz_d     = 1'b1;
                    end
                end
                RINGING: begin
                    if (btn_stop) begin
                        state_d = ARMED;
                        buzz_d  = 1'b0;
                    end else if (btn_snooze) begin
                        state_d      = SNOOZE;
                        snooze_cnt_d = '0;
                        buzz_d       = 1'b0;
                    end else if (trigger) begin
                        ring_cnt_d = '0;
                        buzz_d     = 1'b1;
                    end else if (sec_tick) begin
                        ring_cnt_d = ring_cnt_inc;
                        buzz_d     = ~buzz_q;
                        if (ring_cnt_inc == RING_LIM) begin
                            state_d = ARMED;
                            buzz_d  = 1'b0;
                        end
                    end
                end
                SNOOZE: begin
                    if (btn_stop) begin
                        state_d = ARMED;
                    end else if (trigger) begin
                        state_d    = RINGING;
                        ring_cnt_d = '0;
                        buzz_d     = 1'b1;
                    end else if (sec_tick) begin
                        snooze_cnt_d = snooze_cnt_inc;
                        if (snooze_cnt_inc == SNOOZE_LIM) begin
                            state_d    = RINGING;
                            ring_cnt_d = '0;
                            buzz_d     = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Flags are derived from the next state so the registered outputs track state_q exactly.
    always_comb begin
        ringing_d = (state_d == RINGING);
        armed_d   = (state_d != IDLE);
    end

    assign alarm_hour = alarm_hour_q;
    assign alarm_min  = alarm_min_q;
    assign ringing    = ringing_q;
    assign buzz       = buzz_q;
    assign armed      = armed_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed, table-driven bench for alarm_controller with short ring/snooze periods.
module tb_alarm_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       sec_tick;
    logic [5:0] count_sec;
    logic [5:0] count_min;
    logic [4:0] count_hour;
    logic       arm;
    logic       set_mode;
    logic       btn_hour;
    logic       btn_min;
    logic       btn_stop;
    logic       btn_snooze;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic       ringing;
    logic       buzz;
    logic       armed;

    int total = 0;
    int bad   = 0;

    alarm_controller #(
        .RING_SECONDS  (3),
        .SNOOZE_SECONDS(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sec_tick  (sec_tick),
        .count_sec (count_sec),
        .count_min (count_min),
        .count_hour(count_hour),
        .arm       (arm),
        .set_mode  (set_mode),
        .btn_hour  (btn_hour),
        .btn_min   (btn_min),
        .btn_stop  (btn_stop),
        .btn_snooze(btn_snooze),
        .alarm_hour(alarm_hour),
        .alarm_min (alarm_min),
        .ringing   (ringing),
        .buzz      (buzz),
        .armed     (armed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, arm, sm, bh, bm, stp, snz, tk;
        logic [4:0] h;
        logic [5:0] m, s;
        logic [4:0] eah;
        logic [5:0] eam;
        logic       er, eb, ea;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic a, input logic sm,
                                input logic bh, input logic bm, input logic stp,
                                input logic snz, input logic tk,
                                input int h, input int m, input int s,
                                input int eah, input int eam,
                                input logic er, input logic eb, input logic ea);
        vec_t v;
        v.rst = rst; v.arm = a; v.sm = sm; v.bh = bh; v.bm = bm;
        v.stp = stp; v.snz = snz; v.tk = tk;
        v.h = 5'(h); v.m = 6'(m); v.s = 6'(s);
        v.eah = 5'(eah); v.eam = 6'(eam);
        v.er = er; v.eb = eb; v.ea = ea;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive on the falling edge, let one rising edge sample, look 1 time unit later.
    task automatic apply(input vec_t v);
        @(negedge clk);
        reset = v.rst; arm = v.arm; set_mode = v.sm;
        btn_hour = v.bh; btn_min = v.bm; btn_stop = v.stp; btn_snooze = v.snz;
        sec_tick = v.tk; count_hour = v.h; count_min = v.m; count_sec = v.s;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, ".alarm_hour"}, int'(alarm_hour), int'(v.eah));
        check({tag, ".alarm_min"},  int'(alarm_min),  int'(v.eam));
        check({tag, ".ringing"},    int'(ringing),    int'(v.er));
        check({tag, ".buzz"},       int'(buzz),       int'(v.eb));
        check({tag, ".armed"},      int'(armed),      int'(v.ea));
    endtask

    initial begin
        vec_t v;
        //            rst arm sm bh bm stp snz tk  h   m   s  eah eam er eb ea
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 7, 29, 59, 7, 30, 0, 0, 1)); // arm -> ARMED
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 7, 30,  0, 7, 30, 1, 1, 1)); // match -> ring
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 7, 30,  0, 7, 30, 1, 0, 1)); // tick 1
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 7, 30,  0, 7, 30, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 7, 30,  0, 7, 30, 1, 1, 1)); // tick 2
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 7, 30,  0, 7, 30, 0, 0, 1)); // tick 3 timeout
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 7, 30,  1, 7, 30, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 7, 30,  0, 7, 30, 1, 1, 1)); // retrigger
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 7, 30,  0, 7, 30, 0, 0, 1)); // snooze
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 7, 30,  0, 7, 30, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 7, 30,  0, 7, 30, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 7, 30,  0, 7, 30, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 7, 30,  0, 7, 30, 1, 1, 1)); // 4th tick re-ring
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 7, 30,  0, 7, 30, 0, 0, 1)); // stop+snooze
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 7, 30,  0, 7, 30, 0, 0, 1)); // held match
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 7, 30,  0, 7, 30, 0, 0, 1)); // set mode on
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 7, 30,  0, 7, 30, 0, 0, 1)); // off: no ring
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 7, 30,  0, 7, 30, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 7, 30,  1, 7, 30, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 7, 30,  0, 7, 30, 1, 1, 1)); // ring
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 30,  0, 7, 30, 0, 0, 0)); // disarm
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 7, 30,  0, 7, 30, 0, 0, 1)); // rearm, held
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 7, 30,  1, 7, 30, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 7, 30,  0, 7, 30, 1, 1, 1)); // ring
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 7, 30,  0, 7, 30, 0, 0, 1)); // stop
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 7, 30,  1, 7, 30, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 7, 30,  0, 7, 30, 1, 1, 1)); // ring
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 7, 30,  0, 0,  0, 0, 0, 0)); // reset mid-ring

        reset = 1'b1; arm = 1'b0; set_mode = 1'b0; btn_hour = 1'b0; btn_min = 1'b0;
        btn_stop = 1'b0; btn_snooze = 1'b0; sec_tick = 1'b0;
        count_hour = '0; count_min = '0; count_sec = 6'd1;

        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        check_all("reset", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

        // Enter 07:30 in set mode while disarmed; time parked at 07:29:59.
        for (int i = 0; i < 7; i++) apply(mk(0, 0, 1, 1, 0, 0, 0, 0, 7, 29, 59, 0, 0, 0, 0, 0));
        for (int i = 0; i < 30; i++) apply(mk(0, 0, 1, 0, 1, 0, 0, 0, 7, 29, 59, 0, 0, 0, 0, 0));
        check("set_hour", int'(alarm_hour), 7);
        check("set_min", int'(alarm_min), 30);
        check("set_idle_armed", int'(armed), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            check_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Edit wrap checks from the cleared alarm time left by the reset row.
        for (int i = 1; i <= 24; i++) begin
            apply(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
            check($sformatf("hour_wrap%0d", i), int'(alarm_hour), i % 24);
        end
        for (int i = 1; i <= 61; i++) begin
            apply(mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
            check($sformatf("min_wrap%0d", i), int'(alarm_min), i % 60);
        end
        check("min_no_carry", int'(alarm_hour), 0);
        v = mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0);
        apply(v);
        check_all("both_btn", v);
        v = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0);
        apply(v);
        check_all("btn_ignored", v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
